xgmii_link_supervisor: RTL and testbench
========================================

Name: xgmii_link_supervisor

Overview:
- Parametrised per-channel link supervisor for the 10GBASE-R SerDes subsystem, sitting between the SerDes top wrapper and user logic.
- Generalises the fixed two-port wiring to NUM_CH channels.
- Sequences each channel's SerDes TX/RX resets from SFP LOS and clock lock, qualifies link-up from PLL, CDR and block lock and from BER status, and retries RX alignment on timeout or link loss.
- Accumulates saturating counters of the SerDes debug events for status readout.

Parameters:
- NUM_CH, 2, number of SerDes channels supervised.
- CNT_W, 16, width of each event counter.
- RST_CYCLES, 256, cycles TX/RX resets are held after preconditions are met.
- LOCK_STABLE, 1024, cycles the lock condition must hold continuously before link-up.
- LOCK_TIMEOUT, 1048576, maximum cycles in WAIT_LOCK before a retry.
- HOLDOFF_CYCLES, 4096, cycles the RX reset is held on a retry.
- TX_DIS_IN_RESET, 0, if 1, sfp_tx_disable is asserted while in RESET.

Ports:
- trx_clk_156r25M  in  1  156.25 MHz XGMII/SerDes user clock.
- trx_rstn  in  1  asynchronous, active-low reset.
- trx_clk_locked  in  1  user PLL locked.
- sfp_los  in  NUM_CH  SFP loss of signal (1 = loss); asynchronous input.
- pll_lock, cdr_lock, block_lock, hi_ber  in  NUM_CH each  SerDes status per channel.
- dbg_evt  in  NUM_CH*6  per channel, bits [6c+0..6c+5] = idle_delete, seq_delete, idle_insert, buf_overflow, buf_underflow, gearbox_bitslip.
- cnt_clear  in  NUM_CH  synchronous clear of that channel's counters.
- serdes_tx_rstn, serdes_rx_rstn  out  NUM_CH each  SerDes resets, active-low.
- sfp_tx_disable  out  NUM_CH  laser disable.
- link_up  out  NUM_CH  channel in UP state.
- link_state  out  NUM_CH*2  state code per channel.
- retry_count  out  NUM_CH*8  saturating retry counter per channel.
- evt_count  out  NUM_CH*6*CNT_W  event counters; channel c, event e at offset (6c+e)*CNT_W.

Behaviour:
- Reset values: state RESET; serdes_tx_rstn = serdes_rx_rstn = 0; link_up = 0; all counters 0; sfp_tx_disable = TX_DIS_IN_RESET.
- sfp_los passes through a 2-FF synchroniser per channel (2-cycle latency). All other inputs are synchronous to trx_clk_156r25M.
- Each channel has an independent FSM. Encoding: RESET = 0, WAIT_LOCK = 1, UP = 2, HOLDOFF = 3.
- One timer per channel, sized by $clog2 of the largest parameter. The timer clears on every state change.
- Define go = trx_clk_locked & ~los_sync. Whenever go = 0, the next state is RESET from any state, with priority over all other transitions. The timer is held at 0 while in RESET with go = 0.
- RESET:
  - tx_rstn = rx_rstn = 0.
  - The timer counts while go = 1; at RST_CYCLES-1 the FSM moves to WAIT_LOCK.
  - Both resets go high in the first WAIT_LOCK cycle, exactly RST_CYCLES cycles after go first rises.
- WAIT_LOCK:
  - Resets high. Define ok = pll_lock & cdr_lock & block_lock & ~hi_ber.
  - A stable counter increments while ok = 1 and clears when ok = 0. When it reaches LOCK_STABLE, the FSM moves to UP.
  - When the timer reaches LOCK_TIMEOUT-1 without reaching UP, the FSM moves to HOLDOFF and retry_count increments.
  - If stability completes and the timeout expires in the same cycle, UP wins.
- UP:
  - link_up = 1 (registered with the state).
  - If block_lock = 0 or hi_ber = 1, the FSM moves to HOLDOFF and retry_count increments.
- HOLDOFF:
  - rx_rstn = 0 and tx_rstn stays 1.
  - After HOLDOFF_CYCLES, the FSM returns to WAIT_LOCK.
- retry_count saturates at 255. It is cleared by cnt_clear and is not cleared by RESET.
- Event counters:
  - Each counter increments on a rising edge of its dbg_evt bit (registered edge detect, 1-cycle latency).
  - Counters saturate at all-ones and count in every state.
  - When cnt_clear and an edge occur in the same cycle, clear wins and the counter reads 0.
- sfp_tx_disable = 1 only when TX_DIS_IN_RESET = 1 and the state is RESET.
- Asserting trx_rstn mid-operation returns every output to its reset value asynchronously.
- Channels share no state.

Decomposition:
- Package xgmii_sup_pkg holds:
  - the state encoding localparams (RESET/WAIT_LOCK/UP/HOLDOFF);
  - the event index constants (EVT_IDLE_DEL = 0 … EVT_BITSLIP = 5);
  - NUM_EVT = 6.
- Sub-module xgmii_link_chan: one channel's synchroniser, FSM, timers, and retry and event counters. The top is a generate loop over NUM_CH that slices the flat buses.

Test Plan:
Bench parameters: RST_CYCLES = 4, LOCK_STABLE = 8, LOCK_TIMEOUT = 64, HOLDOFF_CYCLES = 16, NUM_CH = 2.
- Bring-up: release trx_rstn with locked = 1, los = 0, ok = 1 throughout -> tx/rx_rstn rise 4 cycles after synced go; link_up = 1 after 8 further cycles; link_state = 2.
- Timeout retry: ok held 0 -> HOLDOFF after 64 WAIT_LOCK cycles, retry_count = 1, rx_rstn low for 16 cycles with tx_rstn high, then back to WAIT_LOCK. After 300 stuck retries, retry_count reads 255.
- Link loss: in UP, pulse hi_ber for 1 cycle -> link_up drops next cycle, state 3, retry_count +1; relock completes via WAIT_LOCK.
- LOS override: assert sfp_los[1] while both channels are UP -> channel 1 enters RESET within 3 cycles with both resets low; channel 0 is unaffected. With TX_DIS_IN_RESET = 1, sfp_tx_disable[1] = 1.
- Event counters: 5 single-cycle buf_overflow pulses on ch0, plus a 10-cycle-long level pulse -> evt_count[ch0][3] = 6. cnt_clear coincident with an edge -> counter reads 0. With CNT_W = 4, 20 pulses -> counter reads 15.
- Async reset mid-UP: drop trx_rstn -> all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/xgmii_sup_pkg.sv
// Shared definitions for the XGMII link supervisor.
// Holds the state codes, the debug event indices and sizing helpers.
package xgmii_sup_pkg;

    localparam logic [1:0] LS_RESET     = 2'd0;
    localparam logic [1:0] LS_WAIT_LOCK = 2'd1;
    localparam logic [1:0] LS_UP        = 2'd2;
    localparam logic [1:0] LS_HOLDOFF   = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET     = LS_RESET,
        ST_WAIT_LOCK = LS_WAIT_LOCK,
        ST_UP        = LS_UP,
        ST_HOLDOFF   = LS_HOLDOFF
    } link_state_e;

    localparam int NUM_EVT      = 6;
    localparam int EVT_IDLE_DEL = 0;
    localparam int EVT_SEQ_DEL  = 1;
    localparam int EVT_IDLE_INS = 2;
    localparam int EVT_BUF_OVF  = 3;
    localparam int EVT_BUF_UNF  = 4;
    localparam int EVT_BITSLIP  = 5;

    localparam int RETRY_W = 8;

    function automatic int max_of4(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/xgmii_link_chan.sv
// One supervised SerDes channel: LOS synchroniser, link FSM,
// timers, saturating retry counter and debug event counters.
import xgmii_sup_pkg::*;

module xgmii_link_chan #(
    parameter int CNT_W           = 16,
    parameter int RST_CYCLES      = 256,
    parameter int LOCK_STABLE     = 1024,
    parameter int LOCK_TIMEOUT    = 1048576,
    parameter int HOLDOFF_CYCLES  = 4096,
    parameter bit TX_DIS_IN_RESET = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_locked,
    input  logic                     sfp_los,
    input  logic                     pll_lock,
    input  logic                     cdr_lock,
    input  logic                     block_lock,
    input  logic                     hi_ber,
    input  logic [NUM_EVT-1:0]       dbg_evt,
    input  logic                     cnt_clear,
    output logic                     tx_rstn,
    output logic                     rx_rstn,
    output logic                     tx_disable,
    output logic                     link_up,
    output logic [1:0]               link_state,
    output logic [RETRY_W-1:0]       retry_count,
    output logic [NUM_EVT*CNT_W-1:0] evt_count
);

    localparam int TMR_W = clog2_min1(
        max_of4(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, HOLDOFF_CYCLES));

    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLDOFF_CYCLES - 1);

    logic los_s1_q;
    logic los_s2_q;
    logic go;
    logic ok;

    link_state_e state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] stable_q, stable_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic retry_inc;

    logic tx_rstn_q, tx_rstn_d;
    logic rx_rstn_q, rx_rstn_d;
    logic link_up_q, link_up_d;
    logic tx_dis_q, tx_dis_d;

    logic [NUM_EVT-1:0] evt_prev_q;
    logic [NUM_EVT-1:0] evt_rise;
    logic [CNT_W-1:0]   cnt_q [NUM_EVT];
    logic [CNT_W-1:0]   cnt_d [NUM_EVT];

    // Reset to "loss" so a channel never starts before LOS is really sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            los_s1_q <= 1'b1;
            los_s2_q <= 1'b1;
        end else begin
            los_s1_q <= sfp_los;
            los_s2_q <= los_s1_q;
        end
    end

    assign go = clk_locked & ~los_s2_q;
    assign ok = pll_lock & cdr_lock & block_lock & ~hi_ber;

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (ok && stable_q == STABLE_LAST) begin
                    state_d = ST_UP;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d   = ST_HOLDOFF;
                    retry_inc = 1'b1;
                end
            end
            ST_UP: begin
                if (!block_lock || hi_ber) begin
                    state_d   = ST_HOLDOFF;
                    retry_inc = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (timer_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
            end
            default: state_d = ST_RESET;
        endcase
        if (!go) begin
            state_d   = ST_RESET;
            retry_inc = 1'b0;
        end
    end

    always_comb begin
        timer_d  = timer_q + 1'b1;
        stable_d = ok ? stable_q + 1'b1 : '0;
        if (!go || state_d != state_q || state_q == ST_UP) timer_d = '0;
        if (state_d != state_q || state_q != ST_WAIT_LOCK) stable_d = '0;
    end

    always_comb begin
        retry_d = retry_q;
        if (cnt_clear) begin
            retry_d = '0;
        end else if (retry_inc && retry_q != '1) begin
            retry_d = retry_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so they change with it.
    always_comb begin
        tx_rstn_d = (state_d != ST_RESET);
        rx_rstn_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_UP);
        link_up_d = (state_d == ST_UP);
        tx_dis_d  = TX_DIS_IN_RESET && (state_d == ST_RESET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            tx_rstn_q <= 1'b0;
            rx_rstn_q <= 1'b0;
            link_up_q <= 1'b0;
            tx_dis_q  <= TX_DIS_IN_RESET;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            tx_rstn_q <= tx_rstn_d;
            rx_rstn_q <= rx_rstn_d;
            link_up_q <= link_up_d;
            tx_dis_q  <= tx_dis_d;
        end
    end

    assign evt_rise = dbg_evt & ~evt_prev_q;

    always_comb begin
        for (int e = 0; e < NUM_EVT; e++) begin
            cnt_d[e] = cnt_q[e];
            if (cnt_clear) begin
                cnt_d[e] = '0;
            end else if (evt_rise[e] && cnt_q[e] != '1) begin
                cnt_d[e] = cnt_q[e] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_prev_q <= '0;
            for (int e = 0; e < NUM_EVT; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            evt_prev_q <= dbg_evt;
            for (int e = 0; e < NUM_EVT; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
        end
    end

    for (genvar e = 0; e < NUM_EVT; e++) begin : g_evt
        assign evt_count[e*CNT_W +: CNT_W] = cnt_q[e];
    end

    assign tx_rstn     = tx_rstn_q;
    assign rx_rstn     = rx_rstn_q;
    assign tx_disable  = tx_dis_q;
    assign link_up     = link_up_q;
    assign link_state  = state_q;
    assign retry_count = retry_q;

endmodule

// File: rtl/xgmii_link_supervisor.sv
// Per-channel 10GBASE-R link supervisor; one independent
// xgmii_link_chan per SerDes channel on flat status buses.
import xgmii_sup_pkg::*;

module xgmii_link_supervisor #(
    parameter int NUM_CH          = 2,
    parameter int CNT_W           = 16,
    parameter int RST_CYCLES      = 256,
    parameter int LOCK_STABLE     = 1024,
    parameter int LOCK_TIMEOUT    = 1048576,
    parameter int HOLDOFF_CYCLES  = 4096,
    parameter int TX_DIS_IN_RESET = 0
) (
    input  logic                            trx_clk_156r25M,
    input  logic                            trx_rstn,
    input  logic                            trx_clk_locked,
    input  logic [NUM_CH-1:0]               sfp_los,
    input  logic [NUM_CH-1:0]               pll_lock,
    input  logic [NUM_CH-1:0]               cdr_lock,
    input  logic [NUM_CH-1:0]               block_lock,
    input  logic [NUM_CH-1:0]               hi_ber,
    input  logic [NUM_CH*NUM_EVT-1:0]       dbg_evt,
    input  logic [NUM_CH-1:0]               cnt_clear,
    output logic [NUM_CH-1:0]               serdes_tx_rstn,
    output logic [NUM_CH-1:0]               serdes_rx_rstn,
    output logic [NUM_CH-1:0]               sfp_tx_disable,
    output logic [NUM_CH-1:0]               link_up,
    output logic [NUM_CH*2-1:0]             link_state,
    output logic [NUM_CH*RETRY_W-1:0]       retry_count,
    output logic [NUM_CH*NUM_EVT*CNT_W-1:0] evt_count
);

    localparam int EVT_BUS_W = NUM_EVT * CNT_W;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        xgmii_link_chan #(
            .CNT_W          (CNT_W),
            .RST_CYCLES     (RST_CYCLES),
            .LOCK_STABLE    (LOCK_STABLE),
            .LOCK_TIMEOUT   (LOCK_TIMEOUT),
            .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
            .TX_DIS_IN_RESET(TX_DIS_IN_RESET != 0)
        ) u_chan (
            .clk        (trx_clk_156r25M),
            .rst_n      (trx_rstn),
            .clk_locked (trx_clk_locked),
            .sfp_los    (sfp_los[c]),
            .pll_lock   (pll_lock[c]),
            .cdr_lock   (cdr_lock[c]),
            .block_lock (block_lock[c]),
            .hi_ber     (hi_ber[c]),
            .dbg_evt    (dbg_evt[c*NUM_EVT +: NUM_EVT]),
            .cnt_clear  (cnt_clear[c]),
            .tx_rstn    (serdes_tx_rstn[c]),
            .rx_rstn    (serdes_rx_rstn[c]),
            .tx_disable (sfp_tx_disable[c]),
            .link_up    (link_up[c]),
            .link_state (link_state[c*2 +: 2]),
            .retry_count(retry_count[c*RETRY_W +: RETRY_W]),
            .evt_count  (evt_count[c*EVT_BUS_W +: EVT_BUS_W])
        );
    end

endmodule

// File: tb/tb_xgmii_link_supervisor.sv
// Scoreboard bench for xgmii_link_supervisor: random and directed
// stimulus against a count-based reference model of the supervisor.
module tb_xgmii_link_supervisor;

    localparam int NUM_CH = 2;
    localparam int NE     = 6;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int RST_C  = 4;
    localparam int STAB   = 8;
    localparam int TOUT   = 64;
    localparam int HOLD   = 16;
    localparam int EW     = NUM_CH * NE;
    localparam int VW     = 4 + 2 + 8 + NE * CNT_W;

    typedef logic [NUM_CH*VW-1:0] snap_t;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic locked = 1'b1;
    logic [NUM_CH-1:0] los = '0;
    logic [NUM_CH-1:0] pll = '1;
    logic [NUM_CH-1:0] cdr = '1;
    logic [NUM_CH-1:0] bl  = '1;
    logic [NUM_CH-1:0] hb  = '0;
    logic [NUM_CH-1:0] clr = '0;
    logic [EW-1:0]     evt = '0;

    logic [NUM_CH-1:0]          serdes_tx_rstn;
    logic [NUM_CH-1:0]          serdes_rx_rstn;
    logic [NUM_CH-1:0]          sfp_tx_disable;
    logic [NUM_CH-1:0]          link_up;
    logic [NUM_CH*2-1:0]        link_state;
    logic [NUM_CH*8-1:0]        retry_count;
    logic [NUM_CH*NE*CNT_W-1:0] evt_count;

    xgmii_link_supervisor #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .RST_CYCLES     (RST_C),
        .LOCK_STABLE    (STAB),
        .LOCK_TIMEOUT   (TOUT),
        .HOLDOFF_CYCLES (HOLD),
        .TX_DIS_IN_RESET(1)
    ) dut (
        .trx_clk_156r25M(clk),
        .trx_rstn       (rstn),
        .trx_clk_locked (locked),
        .sfp_los        (los),
        .pll_lock       (pll),
        .cdr_lock       (cdr),
        .block_lock     (bl),
        .hi_ber         (hb),
        .dbg_evt        (evt),
        .cnt_clear      (clr),
        .serdes_tx_rstn (serdes_tx_rstn),
        .serdes_rx_rstn (serdes_rx_rstn),
        .sfp_tx_disable (sfp_tx_disable),
        .link_up        (link_up),
        .link_state     (link_state),
        .retry_count    (retry_count),
        .evt_count      (evt_count)
    );

    always #5 clk = ~clk;

    snap_t expq[$];
    int vectors     = 0;
    int miscompares = 0;

    // Model: phase 0..3, progress count within phase, consecutive ok run.
    int m_ls1   [NUM_CH];
    int m_ls2   [NUM_CH];
    int m_ph    [NUM_CH];
    int m_n     [NUM_CH];
    int m_run   [NUM_CH];
    int m_retry [NUM_CH];
    int m_cnt   [NUM_CH][NE];
    int m_prev  [NUM_CH][NE];

    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit go, ok, inc, rise;
            if (!rstn) begin
                m_ls1[c] = 1; m_ls2[c] = 1;
                m_ph[c] = 0; m_n[c] = 0; m_run[c] = 0; m_retry[c] = 0;
                for (int e = 0; e < NE; e++) begin
                    m_cnt[c][e] = 0; m_prev[c][e] = 0;
                end
                continue;
            end
            go  = locked && (m_ls2[c] == 0);
            ok  = pll[c] && cdr[c] && bl[c] && !hb[c];
            inc = 0;
            if (!go) begin
                m_ph[c] = 0; m_n[c] = 0;
            end else if (m_ph[c] == 0) begin
                m_n[c]++;
                if (m_n[c] == RST_C) begin m_ph[c] = 1; m_n[c] = 0; m_run[c] = 0; end
            end else if (m_ph[c] == 1) begin
                m_n[c]++;
                m_run[c] = ok ? m_run[c] + 1 : 0;
                if (m_run[c] == STAB) begin
                    m_ph[c] = 2; m_n[c] = 0;
                end else if (m_n[c] == TOUT) begin
                    m_ph[c] = 3; m_n[c] = 0; inc = 1;
                end
            end else if (m_ph[c] == 2) begin
                if (!bl[c] || hb[c]) begin m_ph[c] = 3; m_n[c] = 0; inc = 1; end
            end else begin
                m_n[c]++;
                if (m_n[c] == HOLD) begin m_ph[c] = 1; m_n[c] = 0; m_run[c] = 0; end
            end
            if (clr[c]) m_retry[c] = 0;
            else if (inc && m_retry[c] < 255) m_retry[c]++;
            for (int e = 0; e < NE; e++) begin
                rise = evt[c*NE+e] && (m_prev[c][e] == 0);
                if (clr[c]) m_cnt[c][e] = 0;
                else if (rise && m_cnt[c][e] < CMAX) m_cnt[c][e]++;
                m_prev[c][e] = int'(evt[c*NE+e]);
            end
            m_ls2[c] = m_ls1[c];
            m_ls1[c] = int'(los[c]);
        end
    endtask

    function automatic logic [VW-1:0] exp_vec(input int c);
        logic [VW-1:0] v;
        v = '0;
        v[VW-1]      = (m_ph[c] != 0);
        v[VW-2]      = (m_ph[c] == 1) || (m_ph[c] == 2);
        v[VW-3]      = (m_ph[c] == 0);
        v[VW-4]      = (m_ph[c] == 2);
        v[VW-5 -: 2] = 2'(m_ph[c]);
        v[VW-7 -: 8] = 8'(m_retry[c]);
        for (int e = 0; e < NE; e++) v[e*CNT_W +: CNT_W] = CNT_W'(m_cnt[c][e]);
        return v;
    endfunction

    function automatic logic [VW-1:0] act_vec(input int c);
        return {serdes_tx_rstn[c], serdes_rx_rstn[c], sfp_tx_disable[c],
                link_up[c], link_state[2*c +: 2], retry_count[8*c +: 8],
                evt_count[c*NE*CNT_W +: NE*CNT_W]};
    endfunction

    task automatic tick();
        snap_t s;
        model_step();
        for (int c = 0; c < NUM_CH; c++) s[c*VW +: VW] = exp_vec(c);
        expq.push_back(s);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic good_inputs();
        locked = 1'b1; los = '0; pll = '1; cdr = '1; bl = '1;
        hb = '0; clr = '0; evt = '0;
    endtask

    task automatic rand_inputs(input int clr_div);
        locked = ($urandom_range(0, 299) != 0);
        for (int c = 0; c < NUM_CH; c++) begin
            los[c] = ($urandom_range(0, 199) == 0);
            pll[c] = ($urandom_range(0, 49) != 0);
            cdr[c] = ($urandom_range(0, 49) != 0);
            bl[c]  = ($urandom_range(0, 39) != 0);
            hb[c]  = ($urandom_range(0, 49) == 0);
            clr[c] = ($urandom_range(0, clr_div) == 0);
        end
        evt = EW'($urandom & $urandom);
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                s = expq.pop_front();
                for (int c = 0; c < NUM_CH; c++) begin
                    vectors++;
                    if (act_vec(c) !== s[c*VW +: VW]) begin
                        miscompares++;
                        $display("FAIL sb ch%0d @%0t got=%h exp=%h",
                                 c, $time, act_vec(c), s[c*VW +: VW]);
                    end
                end
            end
        end
    end

    initial begin : stim
        good_inputs();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        repeat (30) tick();
        chk("bringup_state", 32'(link_state), 32'hA);
        chk("bringup_rstn", 32'({serdes_tx_rstn, serdes_rx_rstn}), 32'hF);

        repeat (1500) begin
            rand_inputs(60);
            tick();
        end

        good_inputs();
        repeat (40) tick();
        chk("los_pre_up", 32'(link_up), 32'h3);
        los[1] = 1'b1;
        repeat (3) tick();
        chk("los_state", 32'(link_state), 32'h2);
        chk("los_rstn", 32'({serdes_tx_rstn, serdes_rx_rstn}), 32'h5);
        chk("los_txdis", 32'(sfp_tx_disable), 32'h2);
        los[1] = 1'b0;
        repeat (30) tick();

        clr = '1;
        tick();
        clr = '0;
        hb[0] = 1'b1;
        tick();
        hb[0] = 1'b0;
        chk("loss_up", 32'(link_up), 32'h2);
        chk("loss_state", 32'(link_state[1:0]), 32'd3);
        chk("loss_retry", 32'(retry_count[7:0]), 32'd1);
        chk("loss_rstn", 32'({serdes_tx_rstn[0], serdes_rx_rstn[0]}), 32'h2);
        repeat (HOLD) tick();
        chk("holdoff_exit", 32'(link_state[1:0]), 32'd1);
        repeat (STAB) tick();
        chk("relock_up", 32'(link_state[1:0]), 32'd2);

        clr = '1;
        tick();
        clr = '0;
        repeat (5) begin
            evt[3] = 1'b1; tick();
            evt[3] = 1'b0; tick();
        end
        evt[3] = 1'b1;
        repeat (10) tick();
        evt[3] = 1'b0;
        tick();
        chk("evt_ovf6", 32'(evt_count[3*CNT_W +: CNT_W]), 32'd6);
        evt[3] = 1'b1; clr[0] = 1'b1;
        tick();
        evt[3] = 1'b0; clr[0] = 1'b0;
        chk("evt_clr_wins", 32'(evt_count[3*CNT_W +: CNT_W]), 32'd0);
        tick();
        repeat (20) begin
            evt[3] = 1'b1; tick();
            evt[3] = 1'b0; tick();
        end
        chk("evt_sat", 32'(evt_count[3*CNT_W +: CNT_W]), 32'd15);
        chk("evt_ch1_iso", 32'(evt_count[NE*CNT_W +: NE*CNT_W]), 32'd0);

        clr = '1;
        tick();
        clr = '0;
        bl = '0; pll = '0;
        tick();
        chk("stuck_retry1", 32'(retry_count), 32'h0101);
        repeat (HOLD + TOUT) tick();
        chk("stuck_retry2", 32'(retry_count), 32'h0202);
        chk("stuck_rstn", 32'({serdes_tx_rstn, serdes_rx_rstn}), 32'hC);
        repeat (300 * (HOLD + TOUT)) tick();
        chk("retry_sat", 32'(retry_count), 32'hFFFF);

        repeat (500) begin
            rand_inputs(20);
            tick();
        end

        good_inputs();
        repeat (40) tick();
        hb = '1;
        tick();
        hb = '0;
        repeat (40) tick();
        chk("arst_pre_up", 32'(link_up), 32'h3);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_tx", 32'(serdes_tx_rstn), 32'h0);
        chk("arst_rx", 32'(serdes_rx_rstn), 32'h0);
        chk("arst_up", 32'(link_up), 32'h0);
        chk("arst_state", 32'(link_state), 32'h0);
        chk("arst_retry", 32'(retry_count), 32'h0);
        chk("arst_txdis", 32'(sfp_tx_disable), 32'h3);
        chk("arst_evt0", 32'(evt_count[0 +: NE*CNT_W]), 32'h0);
        chk("arst_evt1", 32'(evt_count[NE*CNT_W +: NE*CNT_W]), 32'h0);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (25) tick();
        chk("rebring_state", 32'(link_state), 32'hA);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
